// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared types and helpers for the systolic array feeders
package systolic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FEED,
    ST_FLUSH
  } feeder_state_e;

  localparam int DEFAULT_DATA_WIDTH = 32;

  // Width needed to hold a vector count in the range 0..max_k inclusive.
  function automatic int cnt_width(input int max_k);
    return $clog2(max_k + 1);
  endfunction

endpackage

// File: rtl/skew_lane.sv
// rtl/skew_lane.sv - fixed-depth register delay line carrying data plus a valid flag
module skew_lane #(
  parameter int DEPTH      = 1,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid
);

  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]      valid_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < DEPTH; s++) begin
        data_q[s] <= '0;
      end
      valid_q <= '0;
    end else begin
      data_q[0]  <= in_data;
      valid_q[0] <= in_valid;
      for (int s = 1; s < DEPTH; s++) begin
        data_q[s]  <= data_q[s-1];
        valid_q[s] <= valid_q[s-1];
      end
    end
  end

  assign out_data  = data_q[DEPTH-1];
  assign out_valid = valid_q[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// rtl/systolic_skew_feeder.sv - west-edge activation feeder producing the diagonal wavefront
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int  DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int  ROWS       = 4,
  parameter int  MAX_K      = 256,
  localparam int CNT_W      = cnt_width(MAX_K)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [CNT_W-1:0]           k_len,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0] in_data,
  output logic [ROWS*DATA_WIDTH-1:0] act_out,
  output logic [ROWS-1:0]            lane_valid,
  output logic                       advance,
  output logic                       busy,
  output logic                       done
);

  localparam int FL_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  feeder_state_e    state;
  logic [CNT_W-1:0] k_len_q;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_inc;
  logic [FL_W-1:0]  flush_cnt;

  assign count_inc = count + CNT_W'(1);
  assign in_ready  = (state == ST_FEED);
  assign advance   = in_valid && in_ready;
  assign busy      = (state != ST_IDLE);
  // The flush counter reaches zero exactly when the bottom lane shows the last element.
  assign done      = (state == ST_FLUSH) && (flush_cnt == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      k_len_q   <= '0;
      count     <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            k_len_q <= k_len;
            count   <= '0;
            if (k_len == '0) begin
              state     <= ST_FLUSH;
              flush_cnt <= '0;
            end else begin
              state <= ST_FEED;
            end
          end
        end
        ST_FEED: begin
          if (advance) begin
            count <= count_inc;
            if (count_inc == k_len_q) begin
              state     <= ST_FLUSH;
              flush_cnt <= FL_W'(ROWS - 1);
            end
          end
        end
        ST_FLUSH: begin
          if (flush_cnt == '0) begin
            state <= ST_IDLE;
          end else begin
            flush_cnt <= flush_cnt - FL_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Without a handshake, stage 0 takes a zero bubble so the free-running array never sees stale data.
  for (genvar g = 0; g < ROWS; g++) begin : g_lane
    logic [DATA_WIDTH-1:0] lane_in;

    assign lane_in = advance ? in_data[g*DATA_WIDTH +: DATA_WIDTH] : '0;

    skew_lane #(
      .DEPTH      (g + 1),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .in_data   (lane_in),
      .in_valid  (advance),
      .out_data  (act_out[g*DATA_WIDTH +: DATA_WIDTH]),
      .out_valid (lane_valid[g])
    );
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb/tb_systolic_skew_feeder.sv - self-checking bench for systolic_skew_feeder
module tb_systolic_skew_feeder;

  localparam int DW    = 32;
  localparam int ROWS  = 4;
  localparam int CNT_W = 9;
  localparam int HIST  = 8192;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic [CNT_W-1:0]     k_len;
  logic                 in_valid;
  logic                 in_ready;
  logic [ROWS*DW-1:0]   in_data;
  logic [ROWS*DW-1:0]   act_out;
  logic [ROWS-1:0]      lane_valid;
  logic                 advance;
  logic                 busy;
  logic                 done;

  systolic_skew_feeder #(.DATA_WIDTH(DW), .ROWS(ROWS), .MAX_K(256)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .k_len      (k_len),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .act_out    (act_out),
    .lane_valid (lane_valid),
    .advance    (advance),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: job-level bookkeeping plus a history of what was accepted at each edge.
  int             cyc = 0;
  logic [127:0]   hist_d [HIST];
  bit             hist_v [HIST];
  bit             m_busy = 0;
  bit             m_feed = 0;
  int             m_k = 0;
  int             m_acc = 0;
  int             m_done = -10;

  typedef struct {
    logic             start;
    logic [CNT_W-1:0] k;
    logic             valid;
    logic [127:0]     data;
    logic [127:0]     exp_act;
    logic [3:0]       exp_lv;
    logic             exp_done;
    logic             exp_busy;
    logic             exp_ready;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0;
    m_feed = 0;
    m_done = -10;
    for (int j = cyc - ROWS; j <= cyc; j++) begin
      if (j >= 0) hist_v[j] = 0;
    end
  endtask

  task automatic model_edge();
    bit pre_busy;
    bit hs;
    cyc++;
    hist_v[cyc] = 0;
    hist_d[cyc] = '0;
    if (!reset) begin
      model_reset();
      return;
    end
    pre_busy = m_busy;
    hs = in_valid && m_feed;
    if (hs) begin
      hist_v[cyc] = 1;
      hist_d[cyc] = in_data;
      m_acc++;
      if (m_acc == m_k) begin
        m_feed = 0;
        m_done = cyc + ROWS - 1;
      end
    end
    if (pre_busy && m_done == cyc - 1) m_busy = 0;
    if (start && !pre_busy) begin
      m_busy = 1;
      m_k = int'(k_len);
      m_acc = 0;
      if (m_k == 0) begin
        m_feed = 0;
        m_done = cyc;
      end else begin
        m_feed = 1;
      end
    end
  endtask

  task automatic compare_model();
    logic [127:0] ea;
    logic [3:0]   ev;
    ea = '0;
    ev = '0;
    for (int i = 0; i < ROWS; i++) begin
      int j;
      j = cyc - i;
      if (j >= 0 && hist_v[j]) begin
        ea[i*DW +: DW] = hist_d[j][i*DW +: DW];
        ev[i] = 1'b1;
      end
    end
    check("act_out", act_out, ea);
    check("lane_valid", lane_valid, ev);
    check("done", done, m_busy && (m_done == cyc));
    check("busy", busy, m_busy);
    check("in_ready", in_ready, m_feed);
  endtask

  // Drive inputs at the negedge, check advance, take one edge, land on the next negedge.
  task automatic drive_edge(input logic s, input int k, input logic v, input logic [127:0] d);
    start    = s;
    k_len    = CNT_W'(k);
    in_valid = v;
    in_data  = d;
    #1;
    check("advance", advance, v && m_feed && reset);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic run_cycle(input logic s, input int k, input logic v);
    drive_edge(s, k, v, {$urandom, $urandom, $urandom, $urandom});
    compare_model();
  endtask

  initial begin
    int e_first;
    int done_at;
    int guard;
    int k;

    for (int j = 0; j < HIST; j++) begin
      hist_v[j] = 0;
      hist_d[j] = '0;
    end

    tbl[0] = '{1'b1, 9'd1, 1'b0, 128'h0, 128'h0, 4'b0000, 1'b0, 1'b1, 1'b1};
    tbl[1] = '{1'b0, 9'd0, 1'b1, {32'd4, 32'd3, 32'd2, 32'd1},
               {96'h0, 32'd1}, 4'b0001, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 9'd0, 1'b0, 128'h0, {64'h0, 32'd2, 32'h0}, 4'b0010, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 9'd0, 1'b0, 128'h0, {32'h0, 32'd3, 64'h0}, 4'b0100, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 9'd0, 1'b0, 128'h0, {32'd4, 96'h0}, 4'b1000, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 9'd0, 1'b0, 128'h0, 128'h0, 4'b0000, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 9'd0, 1'b1, 128'h5, 128'h0, 4'b0000, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 9'd0, 1'b1, 128'h6, 128'h0, 4'b0000, 1'b0, 1'b0, 1'b0};

    reset    = 1'b0;
    start    = 1'b0;
    k_len    = '0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) begin
      @(posedge clk);
      model_edge();
    end
    @(negedge clk);
    check("reset act_out", act_out, 0);
    check("reset lane_valid", lane_valid, 0);
    check("reset busy/done/ready/adv", {busy, done, in_ready, advance}, 0);
    reset = 1'b1;
    run_cycle(1'b0, 0, 1'b0);

    // Skew check for k_len=1 and a k_len=0 job, against hand-derived vectors.
    for (int r = 0; r < 8; r++) begin
      drive_edge(tbl[r].start, int'(tbl[r].k), tbl[r].valid, tbl[r].data);
      check($sformatf("tbl%0d act_out", r), act_out, tbl[r].exp_act);
      check($sformatf("tbl%0d lane_valid", r), lane_valid, tbl[r].exp_lv);
      check($sformatf("tbl%0d done", r), done, tbl[r].exp_done);
      check($sformatf("tbl%0d busy", r), busy, tbl[r].exp_busy);
      check($sformatf("tbl%0d in_ready", r), in_ready, tbl[r].exp_ready);
    end

    // Continuous stream, k_len=3: done five edges after the first handshake.
    run_cycle(1'b1, 3, 1'b0);
    run_cycle(1'b0, 0, 1'b1);
    e_first = cyc;
    run_cycle(1'b0, 0, 1'b1);
    run_cycle(1'b0, 0, 1'b1);
    done_at = -1;
    for (int c = 0; c < 8; c++) begin
      run_cycle(1'b0, 0, 1'b0);
      if (done === 1'b1) done_at = cyc;
    end
    check("stream done cycle", done_at, e_first + 5);

    // Bubble between two vectors of a k_len=2 job.
    run_cycle(1'b1, 2, 1'b0);
    run_cycle(1'b0, 0, 1'b1);
    run_cycle(1'b0, 0, 1'b0);
    check("bubble lane0 valid", lane_valid[0], 1'b0);
    run_cycle(1'b0, 0, 1'b1);
    repeat (6) run_cycle(1'b0, 0, 1'b0);

    // start during FEED and held through the done cycle.
    run_cycle(1'b1, 3, 1'b0);
    run_cycle(1'b0, 0, 1'b1);
    run_cycle(1'b1, 7, 1'b1);
    run_cycle(1'b1, 7, 1'b1);
    check("ignored start ready", in_ready, 1'b0);
    repeat (5) run_cycle(1'b1, 2, 1'b0);
    run_cycle(1'b0, 0, 1'b1);
    run_cycle(1'b0, 0, 1'b1);
    repeat (6) run_cycle(1'b0, 0, 1'b0);

    // Reset in the middle of FEED drops everything in flight.
    run_cycle(1'b1, 5, 1'b0);
    run_cycle(1'b0, 0, 1'b1);
    run_cycle(1'b0, 0, 1'b1);
    reset = 1'b0;
    model_reset();
    #1;
    check("midreset act_out", act_out, 0);
    check("midreset lane_valid", lane_valid, 0);
    check("midreset busy/done/ready/adv", {busy, done, in_ready, advance}, 0);
    run_cycle(1'b0, 0, 1'b1);
    run_cycle(1'b0, 0, 1'b1);
    reset = 1'b1;
    repeat (8) run_cycle(1'b0, 0, 1'b1);

    // Randomized jobs with random gaps, stray starts and random k_len.
    for (int j = 0; j < 30; j++) begin
      k = $urandom_range(0, 6);
      run_cycle(1'b1, k, $urandom_range(0, 1) == 1);
      guard = 0;
      while (m_busy && guard < 100) begin
        run_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 9), $urandom_range(0, 2) != 0);
        guard++;
      end
      check("random job bounded", guard < 100, 1'b1);
      repeat ($urandom_range(0, 2)) run_cycle(1'b0, 0, $urandom_range(0, 1) == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
